// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x4 keypad scanner.
//   - kp_state_e : scan sequencer states
//   - KP_*       : keypad geometry and the idle (no key) column pattern
//   - kp_low_col : index of the lowest-numbered low bit in an active-low column pattern
package keypad_pkg;

  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    DEBOUNCE = 2'd1,
    HELD     = 2'd2
  } kp_state_e;

  localparam int         KP_ROWS     = 4;
  localparam int         KP_COLS     = 4;
  localparam int         KP_CODE_W   = 4;
  localparam logic [3:0] KP_COL_IDLE = 4'b1111;

  // Lowest active column wins when several keys share the driven row.
  // Scanning from the top down lets the lowest low bit overwrite the others.
  function automatic logic [1:0] kp_low_col(input logic [KP_COLS-1:0] cols);
    logic [1:0] idx;
    idx = 2'd0;
    for (int i = KP_COLS - 1; i >= 0; i--) begin
      if (!cols[i]) idx = 2'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/keypad_col_sync.sv
// Two-flop synchroniser for the asynchronous keypad column lines.
// Ports:
//   clock : system clock
//   reset : asynchronous active-low reset; both stages go to all-ones (idle)
//   d_i   : raw active-low column lines
//   q_o   : synchronised column lines
module keypad_col_sync
  import keypad_pkg::*;
(
  input  logic               clock,
  input  logic               reset,
  input  logic [KP_COLS-1:0] d_i,
  output logic [KP_COLS-1:0] q_o
);

  logic [KP_COLS-1:0] meta_q;
  logic [KP_COLS-1:0] sync_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      meta_q <= KP_COL_IDLE;
      sync_q <= KP_COL_IDLE;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/keypad_scan_ctrl.sv
// Row-scanning keypad sequencer: drives one row low at a time, samples the
// synchronised columns, debounces press and release, and issues a one-cycle
// write request per confirmed key. A sticky flag records keys dropped while
// the FIFO was full.
// Ports:
//   clock, reset   : system clock, asynchronous active-low reset
//   col            : raw active-low columns (asynchronous)
//   full           : FIFO full, sampled only when a key is confirmed
//   clr_overrun    : synchronous clear of overrun (a simultaneous set wins)
//   row            : active-low row drive, exactly one bit low
//   key_code       : {row_idx, col_idx} of the last confirmed key
//   v              : one-cycle write request
//   key_down       : high while a confirmed key is held
//   overrun        : sticky dropped-key flag
// Build option: define KEYPAD_REPEAT_EN to re-emit the held key every
// REPEAT_CYCLES cycles.
module keypad_scan_ctrl
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV      = 16,
  parameter int DEBOUNCE_CNT  = 1000,
  parameter int REPEAT_CYCLES = 250000
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [KP_COLS-1:0]   col,
  input  logic                 full,
  input  logic                 clr_overrun,
  output logic [KP_ROWS-1:0]   row,
  output logic [KP_CODE_W-1:0] key_code,
  output logic                 v,
  output logic                 key_down,
  output logic                 overrun
);

  localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int BW = $clog2(DEBOUNCE_CNT + 1);
  localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);
  localparam logic [BW-1:0] DB_LAST    = BW'(DEBOUNCE_CNT - 1);

  if (SCAN_DIV < 4 || DEBOUNCE_CNT < 2 || REPEAT_CYCLES < 2) begin : g_param_check
    $error("keypad_scan_ctrl: SCAN_DIV >= 4, DEBOUNCE_CNT >= 2, REPEAT_CYCLES >= 2 required");
  end

  logic [KP_COLS-1:0]   col_s;
  kp_state_e            state_q, state_d;
  logic [1:0]           row_idx_q, row_idx_d;
  logic [DW-1:0]        dwell_q, dwell_d;
  logic [BW-1:0]        db_q, db_d;
  logic [KP_COLS-1:0]   col_ref_q, col_ref_d;
  logic [KP_CODE_W-1:0] key_code_q, key_code_d;
  logic                 v_q, v_d;
  logic                 key_down_q, key_down_d;
  logic                 overrun_q, overrun_d;
  logic                 emit;

`ifdef KEYPAD_REPEAT_EN
  localparam int RW = $clog2(REPEAT_CYCLES + 1);
  localparam logic [RW-1:0] REP_LAST = RW'(REPEAT_CYCLES - 1);
  logic [RW-1:0] rep_q, rep_d;
`endif

  keypad_col_sync u_sync (
    .clock (clock),
    .reset (reset),
    .d_i   (col),
    .q_o   (col_s)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= SCAN;
      row_idx_q  <= 2'd0;
      dwell_q    <= '0;
      db_q       <= '0;
      col_ref_q  <= KP_COL_IDLE;
      key_code_q <= '0;
      v_q        <= 1'b0;
      key_down_q <= 1'b0;
      overrun_q  <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
      rep_q      <= '0;
`endif
    end else begin
      state_q    <= state_d;
      row_idx_q  <= row_idx_d;
      dwell_q    <= dwell_d;
      db_q       <= db_d;
      col_ref_q  <= col_ref_d;
      key_code_q <= key_code_d;
      v_q        <= v_d;
      key_down_q <= key_down_d;
      overrun_q  <= overrun_d;
`ifdef KEYPAD_REPEAT_EN
      rep_q      <= rep_d;
`endif
    end
  end

  always_comb begin
    state_d    = state_q;
    row_idx_d  = row_idx_q;
    dwell_d    = dwell_q;
    db_d       = db_q;
    col_ref_d  = col_ref_q;
    key_code_d = key_code_q;
    v_d        = 1'b0;
    key_down_d = key_down_q;
    overrun_d  = clr_overrun ? 1'b0 : overrun_q;
    emit       = 1'b0;

    unique case (state_q)
      SCAN: begin
        if (dwell_q == DWELL_LAST) begin
          dwell_d = '0;
          if (col_s == KP_COL_IDLE) begin
            row_idx_d = row_idx_q + 2'd1;
          end else begin
            col_ref_d = col_s;
            db_d      = '0;
            state_d   = DEBOUNCE;
          end
        end else begin
          dwell_d = dwell_q + DW'(1);
        end
      end

      DEBOUNCE: begin
        if (col_s != col_ref_q) begin
          // Bounce: abandon this row and keep scanning.
          state_d   = SCAN;
          row_idx_d = row_idx_q + 2'd1;
          dwell_d   = '0;
          db_d      = '0;
        end else if (db_q == DB_LAST) begin
          key_code_d = {row_idx_q, kp_low_col(col_ref_q)};
          key_down_d = 1'b1;
          db_d       = '0;
          state_d    = HELD;
          emit       = 1'b1;
        end else begin
          db_d = db_q + BW'(1);
        end
      end

      HELD: begin
        // Counts consecutive idle cycles; any activity restarts the release debounce.
        if (col_s == KP_COL_IDLE) begin
          if (db_q == DB_LAST) begin
            key_down_d = 1'b0;
            state_d    = SCAN;
            row_idx_d  = row_idx_q + 2'd1;
            dwell_d    = '0;
            db_d       = '0;
          end else begin
            db_d = db_q + BW'(1);
          end
        end else begin
          db_d = '0;
        end
      end

      default: state_d = SCAN;
    endcase

`ifdef KEYPAD_REPEAT_EN
    rep_d = '0;
    if (state_q == HELD && state_d == HELD) begin
      if (rep_q == REP_LAST) begin
        emit = 1'b1;
      end else begin
        rep_d = rep_q + RW'(1);
      end
    end
`endif

    // A dropped key sets overrun even if clr_overrun is high this cycle.
    if (emit) begin
      if (full) overrun_d = 1'b1;
      else      v_d       = 1'b1;
    end
  end

  assign row      = ~(4'b0001 << row_idx_q);
  assign key_code = key_code_q;
  assign v        = v_q;
  assign key_down = key_down_q;
  assign overrun  = overrun_q;

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
module tb_keypad_scan_ctrl;
  localparam int SCAN_DIV      = 4;
  localparam int DEBOUNCE_CNT  = 8;
  localparam int REPEAT_CYCLES = 40;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] col;
  logic       full = 1'b0;
  logic       clr_overrun = 1'b0;
  logic [3:0] row;
  logic [3:0] key_code;
  logic       v;
  logic       key_down;
  logic       overrun;

  int checks = 0;
  int errors = 0;

  keypad_scan_ctrl #(
    .SCAN_DIV      (SCAN_DIV),
    .DEBOUNCE_CNT  (DEBOUNCE_CNT),
    .REPEAT_CYCLES (REPEAT_CYCLES)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .col         (col),
    .full        (full),
    .clr_overrun (clr_overrun),
    .row         (row),
    .key_code    (key_code),
    .v           (v),
    .key_down    (key_down),
    .overrun     (overrun)
  );

  always #5 clock = ~clock;

  // Physical keypad: pressed keys pull their columns low only while their row is driven.
  logic       press_en = 1'b0;
  logic [1:0] press_row = 2'd0;
  logic [3:0] press_mask = 4'd0;
  always_comb begin
    col = 4'b1111;
    if (press_en && row[press_row] == 1'b0) col = ~press_mask;
  end

  // Write-request monitor, sampled mid-cycle.
  int         v_cnt = 0;
  int         v_consec = 0;
  int         v_nokd = 0;
  logic [3:0] last_v_code = 4'd0;
  logic       v_prev = 1'b0;
  always @(negedge clock) begin
    if (v === 1'b1) begin
      v_cnt++;
      last_v_code = key_code;
      if (v_prev) v_consec++;
      if (key_down !== 1'b1) v_nokd++;
    end
    v_prev = (v === 1'b1);
  end

  typedef struct {
    logic [1:0] r;
    logic [3:0] m;
    logic       f;
    logic       clr;
    logic [3:0] code;
    int         nv;
    logic       ov;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clock);
    #1;
  endtask

  // Waits for the first cycle in which row becomes target.
  task automatic wait_row(input logic [3:0] target, input string name);
    int n;
    n = 0;
    while (row === target && n < 200) begin tick(); n++; end
    while (row !== target && n < 200) begin tick(); n++; end
    if (row !== target) chk(name, row, target);
  endtask

  task automatic wait_v(input string name);
    int n;
    n = 0;
    while (v !== 1'b1 && n < 100) begin tick(); n++; end
    if (v !== 1'b1) chk(name, v, 1);
  endtask

  // Reference rule: code is {row, lowest pressed column}.
  function automatic logic [3:0] model_code(input logic [1:0] r, input logic [3:0] m);
    for (int i = 0; i < 4; i++) if (m[i]) return {r, 2'(i)};
    return 4'd0;
  endfunction

  task automatic episode(input logic [1:0] r, input logic [3:0] m, input logic f, input int hold,
                         input logic clr, input logic [3:0] exp_code, input int exp_v,
                         input logic exp_ov, input string tag);
    int base;
    base = v_cnt;
    full = f;
    press_row = r;
    press_mask = m;
    press_en = 1'b1;
    tick(hold);
    press_en = 1'b0;
    tick(20);
    chk({tag, "_vcount"}, v_cnt - base, exp_v);
    if (exp_v > 0) chk({tag, "_vcode"}, last_v_code, exp_code);
    chk({tag, "_key_code"}, key_code, exp_code);
    chk({tag, "_key_down"}, key_down, 0);
    chk({tag, "_overrun"}, overrun, exp_ov);
    full = 1'b0;
    if (clr) begin
      clr_overrun = 1'b1;
      tick();
      clr_overrun = 1'b0;
      chk({tag, "_clr"}, overrun, 0);
    end
  endtask

  initial begin
    vec_t       tbl [6];
    int         base, first;
    logic [3:0] e;
    logic       ov_m;
    logic [3:0] code_m;

    tbl[0] = '{2'd2, 4'b0010, 1'b0, 1'b0, 4'b1001, 1, 1'b0};
    tbl[1] = '{2'd0, 4'b1000, 1'b1, 1'b0, 4'b0011, 0, 1'b1};
    tbl[2] = '{2'd1, 4'b0001, 1'b0, 1'b0, 4'b0100, 1, 1'b1};
    tbl[3] = '{2'd3, 4'b0101, 1'b0, 1'b1, 4'b1100, 1, 1'b1};
    tbl[4] = '{2'd1, 4'b1111, 1'b0, 1'b0, 4'b0100, 1, 1'b0};
    tbl[5] = '{2'd0, 4'b0001, 1'b1, 1'b1, 4'b0000, 0, 1'b1};

    // Reset values and idle scan sequence
    tick(3);
    chk("rst_row", row, 4'b1110);
    chk("rst_key_code", key_code, 0);
    chk("rst_v", v, 0);
    chk("rst_key_down", key_down, 0);
    chk("rst_overrun", overrun, 0);
    reset = 1'b1;
    for (int i = 0; i <= 32; i++) begin
      e = ~(4'b0001 << ((i / SCAN_DIV) % 4));
      chk($sformatf("scan_row_%0d", i), row, e);
      tick();
    end
    chk("scan_no_v", v_cnt, 0);

    // Press latency: row 2, col 1
    wait_row(4'b1011, "lat_wait_row2");
    press_row = 2'd2; press_mask = 4'b0010; press_en = 1'b1;
    first = -1;
    for (int k = 1; k <= 14; k++) begin
      tick();
      if (v === 1'b1 && first < 0) begin
        first = k;
        chk("lat_code", key_code, 4'b1001);
        chk("lat_key_down", key_down, 1);
      end
    end
    chk("lat_cycle", first, SCAN_DIV - 1 + DEBOUNCE_CNT + 1);
    press_en = 1'b0;
    tick(DEBOUNCE_CNT + 1);
    chk("rel_key_down_still", key_down, 1);
    tick();
    chk("rel_key_down_off", key_down, 0);
    chk("rel_row_next", row, 4'b0111);

    // Bounce on row 1: 5-cycle press
    base = v_cnt;
    wait_row(4'b1101, "bnc_wait_row1");
    press_row = 2'd1; press_mask = 4'b0001; press_en = 1'b1;
    tick(5);
    press_en = 1'b0;
    tick(3);
    chk("bnc_row_adv", row, 4'b1011);
    chk("bnc_no_v", v_cnt - base, 0);
    tick(SCAN_DIV);
    chk("bnc_scan_cont", row, 4'b0111);
    chk("bnc_key_code_kept", key_code, 4'b1001);

    // Dropped key with clr_overrun held high: the set wins on the confirm edge
    full = 1'b1; clr_overrun = 1'b1;
    press_row = 2'd0; press_mask = 4'b1000; press_en = 1'b1;
    first = 0;
    while (key_down !== 1'b1 && first < 100) begin tick(); first++; end
    chk("setwin_confirm", key_down, 1);
    chk("setwin_v", v, 0);
    chk("setwin_overrun", overrun, 1);
    tick();
    chk("setwin_cleared", overrun, 0);
    press_en = 1'b0; full = 1'b0; clr_overrun = 1'b0;
    tick(20);

    // Table-driven press episodes
    for (int t = 0; t < 6; t++) begin
      episode(tbl[t].r, tbl[t].m, tbl[t].f, 35, tbl[t].clr, tbl[t].code, tbl[t].nv, tbl[t].ov,
              $sformatf("tbl%0d", t));
    end

    // Randomised episodes against the transaction-level model
    ov_m = 1'b0;
    code_m = key_code;
    for (int n = 0; n < 12; n++) begin
      logic [1:0] r;
      logic [3:0] m;
      logic       f, clr;
      r = 2'($urandom_range(3, 0));
      m = 4'($urandom_range(15, 1));
      f = ($urandom_range(3, 0) == 0);
      clr = ($urandom_range(2, 0) == 0);
      if ($urandom_range(1, 0) == 1) begin
        base = v_cnt;
        press_row = 2'($urandom_range(3, 0));
        press_mask = 4'($urandom_range(15, 1));
        press_en = 1'b1;
        tick($urandom_range(DEBOUNCE_CNT, 1));
        press_en = 1'b0;
        tick(14);
        chk($sformatf("rnd%0d_bounce_no_v", n), v_cnt - base, 0);
        chk($sformatf("rnd%0d_bounce_code", n), key_code, code_m);
      end
      code_m = model_code(r, m);
      if (f) ov_m = 1'b1;
      episode(r, m, f, 30 + $urandom_range(10, 0), clr, code_m, f ? 0 : 1, ov_m,
              $sformatf("rnd%0d", n));
      if (clr) ov_m = 1'b0;
    end

    // Asynchronous reset in the cycle a key is issued
    press_row = 2'd3; press_mask = 4'b0100; press_en = 1'b1;
    wait_v("hrst_wait_v");
    reset = 1'b0;
    #1;
    chk("hrst_row", row, 4'b1110);
    chk("hrst_key_down", key_down, 0);
    chk("hrst_v", v, 0);
    chk("hrst_key_code", key_code, 0);
    press_en = 1'b0;
    tick(2);
    reset = 1'b1;
    chk("hrst_resume_row0", row, 4'b1110);
    tick(SCAN_DIV);
    chk("hrst_resume_row1", row, 4'b1101);

`ifdef KEYPAD_REPEAT_EN
    // Auto-repeat while held
    press_row = 2'd1; press_mask = 4'b0010; press_en = 1'b1;
    wait_v("rep_wait_v");
    base = v_cnt;
    first = -1;
    for (int k = 1; k <= 100; k++) begin
      tick();
      if (v === 1'b1) begin
        if (first < 0) begin
          first = k;
          chk("rep_first_at", k, REPEAT_CYCLES);
        end else begin
          chk("rep_second_at", k, 2 * REPEAT_CYCLES);
        end
        chk($sformatf("rep_code_%0d", k), key_code, 4'b0101);
      end
    end
    press_en = 1'b0;
    tick(20);
    chk("rep_count", v_cnt - base, 2);
`endif

    chk("v_never_back_to_back", v_consec, 0);
    chk("v_with_key_down", v_nokd, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish, checks %0d errors %0d", checks, errors);
    $fatal(1, "timeout");
  end

endmodule
